ksub16b_seq: RTL and testbench

//  Multi-cycle 16-bit subtractor: the inverse of the 16-bit Kogge-Stone adder. Computes d = k - t - bin.

---
 rtl/ks_arith_pkg.sv | 21 ++
 rtl/ksub16b_seq_if.sv | 36 +++
 rtl/ksub16b_seq_sub_slice.sv | 44 ++++
 rtl/ksub16b_seq.sv | 133 +++++++++++++
 tb/tb_ksub16b_seq.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ks_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ks_arith_pkg
//  Description : Shared sizing and FSM state encoding for the sequential
//                Kogge-Stone arithmetic engines.
//  Revision    : 1.0  initial release
// ============================================================================
package ks_arith_pkg;

    localparam int c_ks_width  = 16;
    localparam int c_ks_slice  = 4;
    localparam int c_ks_nslice = c_ks_width / c_ks_slice;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } ks_state_e;

endpackage : ks_arith_pkg
`default_nettype wire

// File: rtl/ksub16b_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : ksub16b_seq_if
//  Description : Operand and result valid/ready bundle of the sequential
//                subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
interface ksub16b_seq_if
    import ks_arith_pkg::*;
#(
    parameter int WIDTH = c_ks_width
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] t;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, k, t, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );

    modport slave (
        input  in_valid, k, t, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );

endinterface : ksub16b_seq_if
`default_nettype wire

// File: rtl/ksub16b_seq_sub_slice.sv
`default_nettype none
// ============================================================================
//  Module      : sub_slice
//  Description : Combinational SLICE-bit ripple subtractor with borrow in/out,
//                built from gate primitives.
//  Revision    : 1.0  initial release
// ============================================================================
module sub_slice #(
    parameter int SLICE = 4
) (
    input  wire [SLICE-1:0] i_a,
    input  wire [SLICE-1:0] i_b,
    input  wire             i_bin,
    output wire [SLICE-1:0] o_diff,
    output wire             o_bout
);

    wire [SLICE:0] w_brw;

    assign w_brw[0] = i_bin;

    generate
        for (genvar i = 0; i < SLICE; i++) begin : g_bit
            wire w_axb;
            wire w_na;
            wire w_gen;
            wire w_nxb;
            wire w_prop;

            xor u_x0 (w_axb, i_a[i], i_b[i]);
            xor u_x1 (o_diff[i], w_axb, w_brw[i]);
            // borrow = (~a & b) | (~(a ^ b) & borrow_in)
            not u_n0 (w_na, i_a[i]);
            and u_a0 (w_gen, w_na, i_b[i]);
            not u_n1 (w_nxb, w_axb);
            and u_a1 (w_prop, w_nxb, w_brw[i]);
            or  u_o0 (w_brw[i+1], w_gen, w_prop);
        end
    endgenerate

    assign o_bout = w_brw[SLICE];

endmodule : sub_slice
`default_nettype wire

// File: rtl/ksub16b_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ksub16b_seq
//  Description : Multi-cycle subtractor d = k - t - bin, one SLICE-bit slice
//                per clock, LSB first, with a registered borrow chain.
//  Revision    : 1.0  initial release
// ============================================================================
module ksub16b_seq
    import ks_arith_pkg::*;
#(
    parameter int WIDTH = c_ks_width,
    parameter int SLICE = c_ks_slice
) (
    input  logic            clk,
    input  logic            rst_n,
    ksub16b_seq_if.slave    bus
);

    localparam int c_nslice = WIDTH / SLICE;
    localparam int c_idx_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_nslice - 1);

    ks_state_e          r_state;
    ks_state_e          w_state_nxt;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH-1:0]   r_k;
    logic [WIDTH-1:0]   r_t;
    logic               r_borrow;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_d;
    logic               r_bout;
    logic               r_ovf;

    logic               w_in_ready;
    logic               w_accept;
    logic [SLICE-1:0]   w_k_s;
    logic [SLICE-1:0]   w_t_s;
    logic [SLICE-1:0]   w_diff;
    logic               w_slice_bout;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               w_ovf_nxt;

    // Held low through reset so nothing is accepted before the block is live.
    assign w_in_ready = rst_n & ((r_state == IDLE) | ((r_state == DONE) & bus.out_ready));
    assign w_accept   = bus.in_valid & w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.d         = r_d;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;

    assign w_k_s = r_k[r_idx*SLICE +: SLICE];
    assign w_t_s = r_t[r_idx*SLICE +: SLICE];

    sub_slice #(
        .SLICE (SLICE)
    ) u_sub_slice (
        .i_a    (w_k_s),
        .i_b    (w_t_s),
        .i_bin  (r_borrow),
        .o_diff (w_diff),
        .o_bout (w_slice_bout)
    );

    always_comb begin
        w_acc_nxt                       = r_acc;
        w_acc_nxt[r_idx*SLICE +: SLICE] = w_diff;
    end

    assign w_ovf_nxt = (r_k[WIDTH-1] != r_t[WIDTH-1]) && (w_acc_nxt[WIDTH-1] != r_k[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_idx == c_idx_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = bus.in_valid ? CALC : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Partial slices build up in r_acc; d only changes when a result completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_k      <= '0;
            r_t      <= '0;
            r_borrow <= 1'b0;
            r_acc    <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_k      <= bus.k;
            r_t      <= bus.t;
            r_borrow <= bus.bin;
            r_idx    <= '0;
        end else if (r_state == CALC) begin
            r_acc    <= w_acc_nxt;
            r_borrow <= w_slice_bout;
            if (r_idx == c_idx_last) begin
                r_d    <= w_acc_nxt;
                r_bout <= w_slice_bout;
                r_ovf  <= w_ovf_nxt;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule : ksub16b_seq
`default_nettype wire

// File: tb/tb_ksub16b_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ksub16b_seq
//  Description : Directed and randomised self-checking bench for ksub16b_seq.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ksub16b_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ksub16b_seq_if #(.WIDTH(16)) bus ();

    ksub16b_seq #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: {ovf, bout, d}
    function automatic logic [17:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] r;
        logic        v;
        r = {1'b0, a} - {1'b0, b} - {16'b0, c};
        v = (a[15] != b[15]) && (r[15] != a[15]);
        return {v, r[16], r[15:0]};
    endfunction

    // Presents one operand set and returns at the negedge after the accepting edge.
    task automatic send_op(input logic [15:0] kk, input logic [15:0] tt, input logic bb);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.k        = kk;
        bus.t        = tt;
        bus.bin      = bb;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            n_cmp++; n_bad++;
            $display("FAIL send_op_timeout: in_ready never rose");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.k        = 16'hDEAD;
        bus.t        = 16'hBEEF;
        bus.bin      = 1'b1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.k         = '0;
        bus.t         = '0;
        bus.bin       = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.bout, bus.ovf, bus.d} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b bout=%b ovf=%b d=%h, want all 0",
                     bus.in_ready, bus.out_valid, bus.bout, bus.ovf, bus.d);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] vk [4];
        logic [15:0] vt [4];
        logic        vb [4];
        logic [17:0] ve [4];
        int          lat;
        vk = '{16'h0005, 16'h0000, 16'h8000, 16'hFFFF};
        vt = '{16'h0003, 16'h0001, 16'h0001, 16'hFFFF};
        vb = '{1'b0,     1'b0,     1'b0,     1'b1};
        ve = '{{2'b00, 16'h0002}, {2'b01, 16'hFFFF}, {2'b10, 16'h7FFF}, {2'b01, 16'hFFFF}};
        for (int i = 0; i < 4; i++) begin
            send_op(vk[i], vt[i], vb[i]);
            wait_valid(lat);
            n_cmp++;
            if (lat !== 4) begin
                n_bad++;
                $display("FAIL vec%0d_latency: got %0d want 4", i, lat);
            end
            n_cmp++;
            if ({bus.ovf, bus.bout, bus.d} !== ve[i]) begin
                n_bad++;
                $display("FAIL vec%0d_result: got ovf=%b bout=%b d=%h want ovf=%b bout=%b d=%h",
                         i, bus.ovf, bus.bout, bus.d, ve[i][17], ve[i][16], ve[i][15:0]);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL vec%0d_release: got vld=%b rdy=%b want vld=0 rdy=1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        send_op(16'h1234, 16'h0234, 1'b0);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if ({bus.out_valid, bus.in_ready, bus.ovf, bus.bout, bus.d} !== {4'b1000, 16'h1000}) begin
                n_bad++;
                $display("FAIL hold_c%0d: got vld=%b rdy=%b ovf=%b bout=%b d=%h want vld=1 rdy=0 ovf=0 bout=0 d=1000",
                         c, bus.out_valid, bus.in_ready, bus.ovf, bus.bout, bus.d);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.k         = 16'h7FFF;
        bus.t         = 16'hFFFF;
        bus.bin       = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL handoff_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.k         = 16'h0000;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.d !== 16'h1000) begin
            n_bad++;
            $display("FAIL handoff_calc: got vld=%b d=%h want vld=0 d=1000", bus.out_valid, bus.d);
        end
        wait_valid(lat);
        n_cmp++;
        if (lat !== 4) begin
            n_bad++;
            $display("FAIL handoff_latency: got %0d want 4", lat);
        end
        n_cmp++;
        if ({bus.ovf, bus.bout, bus.d} !== {2'b11, 16'h8000}) begin
            n_bad++;
            $display("FAIL handoff_result: got ovf=%b bout=%b d=%h want ovf=1 bout=1 d=8000",
                     bus.ovf, bus.bout, bus.d);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        send_op(16'hA5A5, 16'h5A5A, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.bout, bus.ovf, bus.d} !== 20'h0 || dut.r_state !== 2'd0) begin
            n_bad++;
            $display("FAIL midreset_clear: got rdy=%b vld=%b bout=%b ovf=%b d=%h st=%0d want all 0",
                     bus.in_ready, bus.out_valid, bus.bout, bus.ovf, bus.d, dut.r_state);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_novalid_c%0d: got vld=%b want 0", c, bus.out_valid);
            end
            if (c == 2) rst_n = 1'b1;
        end
        send_op(16'h0100, 16'h0001, 1'b1);
        wait_valid(lat);
        n_cmp++;
        if (lat !== 4 || {bus.ovf, bus.bout, bus.d} !== {2'b00, 16'h00FE}) begin
            n_bad++;
            $display("FAIL postreset_result: got lat=%0d ovf=%b bout=%b d=%h want lat=4 ovf=0 bout=0 d=00fe",
                     lat, bus.ovf, bus.bout, bus.d);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [17:0] expq [$];
        logic [17:0] exp_v;
        logic [17:0] prev_res;
        logic        prev_ov;
        logic        prev_hs;
        logic        clr_iv;
        int          sent;
        int          got;
        int          cycles;
        localparam int NOPS = 2000;
        sent = 0; got = 0; cycles = 0;
        prev_ov = 1'b0; prev_hs = 1'b0; clr_iv = 1'b0; prev_res = '0;
        while ((sent < NOPS || expq.size() != 0) && cycles < 40000) begin
            @(negedge clk);
            cycles++;
            if (prev_ov && !prev_hs) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || {bus.ovf, bus.bout, bus.d} !== prev_res) begin
                    n_bad++;
                    $display("FAIL rand_hold: got vld=%b res=%h want vld=1 res=%h",
                             bus.out_valid, {bus.ovf, bus.bout, bus.d}, prev_res);
                end
            end
            if (clr_iv) bus.in_valid = 1'b0;
            clr_iv = 1'b0;
            if (!bus.in_valid && sent < NOPS && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.k        = 16'($urandom);
                bus.t        = 16'($urandom);
                bus.bin      = 1'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            prev_hs = bus.out_valid & bus.out_ready;
            if (prev_hs) begin
                got++;
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand_extra: unexpected result %h", {bus.ovf, bus.bout, bus.d});
                end else begin
                    exp_v = expq.pop_front();
                    if ({bus.ovf, bus.bout, bus.d} !== exp_v) begin
                        n_bad++;
                        $display("FAIL rand_result%0d: got %h want %h", got, {bus.ovf, bus.bout, bus.d}, exp_v);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(ref_sub(bus.k, bus.t, bus.bin));
                sent++;
                clr_iv = 1'b1;
            end
            prev_ov  = bus.out_valid;
            prev_res = {bus.ovf, bus.bout, bus.d};
        end
        n_cmp++;
        if (got !== NOPS || expq.size() != 0) begin
            n_bad++;
            $display("FAIL rand_count: got %0d results (%0d pending) want %0d", got, expq.size(), NOPS);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ksub16b_seq
`default_nettype wire
